// File: rtl/rle_decode_fifo.sv
// Run-length decoding FIFO: buffers DEPTH (count, data) run entries and replays
// each data word 'count' times on a valid/ready stream, flagging the final beat.
// Entries with a zero count are dropped at the write port.
// Optional feature macro: RLD_LEVEL_EN adds the 'level' output (stored entries).
module rle_decode_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned CW    = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic [CW-1:0]            wr_cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic                     out_last
`ifdef RLD_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    // Entry storage: {count, data}; contents need no reset
    logic [CW+DW-1:0] r_mem [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_rep;
    logic          r_overflow;

    logic [CW+DW-1:0] w_head;
    logic [CW-1:0]    w_head_cnt;
    logic [CW-1:0]    w_rep_final;
    logic             w_full;
    logic             w_empty;
    logic             w_wr_nonzero;
    logic             w_wr_acc;
    logic             w_xfer;
    logic             w_last;
    logic             w_pop;

    // Status, head-of-queue decode and handshake qualification
    always_comb begin
        w_full       = (r_count == FullCount);
        w_empty      = (r_count == '0);
        w_wr_nonzero = (wr_cnt != '0);
        // Full blocks a write even if the head is popped on the same edge
        w_wr_acc     = wr_en && !w_full && w_wr_nonzero;
        w_head       = r_mem[r_rd_ptr];
        w_head_cnt   = w_head[CW+DW-1:DW];
        w_rep_final  = w_head_cnt - CW'(1);
        w_last       = (r_rep == w_rep_final);
        w_xfer       = !w_empty && out_ready;
        w_pop        = w_xfer && w_last;
    end

    // Outputs are pure functions of registered state
    always_comb begin
        full      = w_full;
        empty     = w_empty;
        overflow  = r_overflow;
        out_valid = !w_empty;
        out_data  = w_head[DW-1:0];
        out_last  = w_last;
    end

`ifdef RLD_LEVEL_EN
    // Stored entry count exposed directly from the occupancy counter
    always_comb begin
        level = r_count;
    end
`endif

    // Entry write port; zero-count and overflowing writes never touch memory
    always_ff @(posedge CLK) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {wr_cnt, wr_data};
        end
    end

    // Pointers, occupancy counter, replay counter and sticky overflow flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rep      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr_acc, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_xfer) begin
                r_rep <= w_last ? '0 : r_rep + CW'(1);
            end
            // Zero-count writes are silently dropped, even when full
            if (wr_en && w_full && w_wr_nonzero) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rle_decode_fifo.sv
// Self-checking bench for rle_decode_fifo (DW=8, CW=4, DEPTH=8).
// Expected beats are queued when an entry is written and compared as the DUT
// transfers them; define RLD_LEVEL_EN to also check the 'level' output.
module tb_rle_decode_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 8;

    logic          CLK;
    logic          RST;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] wr_cnt;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef RLD_LEVEL_EN
    logic [3:0]    level;
`endif

    rle_decode_fifo #(
        .DW    (DW),
        .CW    (CW),
        .DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_cnt    (wr_cnt),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef RLD_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Expected beats: {last, data}
    logic [DW:0] exp_q[$];
    int          m_level = 0;
    logic        m_overflow = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one write for a single cycle; the model decides acceptance
    task automatic write(input logic [DW-1:0] d, input logic [CW-1:0] c);
        wr_en   = 1'b1;
        wr_data = d;
        wr_cnt  = c;
        if (c != '0) begin
            if (m_level < DEPTH) begin
                for (int i = 0; i < int'(c); i++) begin
                    exp_q.push_back({(i == int'(c) - 1), d});
                end
                m_level++;
            end else begin
                m_overflow = 1'b1;
            end
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            tick();
            n++;
        end
        check("drain_done", {31'd0, (n < 300)}, 32'd1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        exp_q.delete();
        m_level    = 0;
        m_overflow = 1'b0;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef RLD_LEVEL_EN
        check("rst_level", {28'd0, level}, 32'd0);
`endif
        tick();
        RST = 1'b0;
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (!RST && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {23'd0, out_last, out_data}, 32'hFFFF);
            end else if (out_ready) begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                check("beat_data", {24'd0, out_data}, {24'd0, e[DW-1:0]});
                check("beat_last", {31'd0, out_last}, {31'd0, e[DW]});
                if (e[DW]) m_level--;
            end else begin
                check("stall_data", {24'd0, out_data}, {24'd0, exp_q[0][DW-1:0]});
                check("stall_last", {31'd0, out_last}, {31'd0, exp_q[0][DW]});
            end
        end
    end

    initial begin
        RST       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        wr_cnt    = '0;
        out_ready = 1'b0;
        tick();
        do_reset();

        // T1: reset in the middle of a run after two beats
        out_ready = 1'b1;
        write(8'hA5, 4'd5);
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("t1_no_replay", {31'd0, out_valid}, 32'd0);
            tick();
        end

        // T2: two runs back to back, no bubbles
        out_ready = 1'b1;
        write(8'h11, 4'd3);
        check("t2_first_valid", {31'd0, out_valid}, 32'd1);
        check("t2_first_data", {24'd0, out_data}, 32'h11);
        write(8'h22, 4'd1);
        tick();
        tick();
        check("t2_run2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_run2_data", {24'd0, out_data}, 32'h22);
        check("t2_run2_last", {31'd0, out_last}, 32'd1);
        tick();
        check("t2_empty", {31'd0, empty}, 32'd1);

        // T3: alternating backpressure
        out_ready = 1'b0;
        write(8'h3C, 4'd4);
        for (int i = 0; i < 10; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        check("t3_empty", {31'd0, empty}, 32'd1);
        drain();

        // T4: fill to full, one overflowing write, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            write(DW'(i), 4'd1);
            if (i == 7) check("t4_full", {31'd0, full}, 32'd1);
        end
        check("t4_full_after9", {31'd0, full}, 32'd1);
        check("t4_ovf", {31'd0, overflow}, {31'd0, m_overflow});
        write(8'hEE, 4'd0);
        check("t4_ovf_zero", {31'd0, overflow}, {31'd0, m_overflow});
`ifdef RLD_LEVEL_EN
        check("t4_level", {28'd0, level}, 32'd8);
`endif
        drain();
        check("t4_ovf_kept", {31'd0, overflow}, 32'd1);
        do_reset();

        // T5: zero-count entry filtered
        out_ready = 1'b0;
        write(8'h77, 4'd0);
        check("t5_empty", {31'd0, empty}, 32'd1);
`ifdef RLD_LEVEL_EN
        check("t5_level0", {28'd0, level}, 32'd0);
`endif
        write(8'h88, 4'd2);
        check("t5_nonempty", {31'd0, empty}, 32'd0);
`ifdef RLD_LEVEL_EN
        check("t5_level1", {28'd0, level}, 32'd1);
`endif
        drain();
`ifdef RLD_LEVEL_EN
        check("t5_level_end", {28'd0, level}, 32'd0);
`endif

        // T6: seven stored, concurrent write and pop across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) write(DW'(8'h40 + i), 4'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write(DW'(8'h60 + i), 4'd1);
            check("t6_full", {31'd0, full}, 32'd0);
            check("t6_empty", {31'd0, empty}, 32'd0);
`ifdef RLD_LEVEL_EN
            check("t6_level", {28'd0, level}, 32'd7);
`endif
        end
        drain();
        check("t6_end_empty", {31'd0, empty}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
